// File: rtl/sdram_burst_read.sv
// SDRAM burst read engine: ACT, tRCD wait, READ (optional auto-precharge), then
// captures BURST_LEN beats from dq_in and presents them as one packed word.
module sdram_burst_read #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int BA_W      = 2,
    parameter int DQ_W      = 16,
    parameter int BURST_LEN = 2,
    parameter int TRCD      = 2,
    parameter int RD_DLY    = 3,
    parameter bit AUTO_PRE  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_req_i,
    input  logic [ROW_W-1:0]              rd_row_i,
    input  logic [COL_W-1:0]              rd_col_i,
    input  logic [BA_W-1:0]               rd_bank_i,
    output logic                          rd_ack_o,
    output logic                          busy_o,
    output logic [4+1+ROW_W+BA_W-1:0]     rd_bus_o,
    input  logic [DQ_W-1:0]               dq_in_i,
    output logic [DQ_W*BURST_LEN-1:0]     rd_data_o,
    output logic                          rd_valid_o
);

    localparam int CNT_W = 8;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_TRCD, S_READ, S_CAS, S_DATA, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [BA_W-1:0]           bank_q, bank_d;
    logic [DQ_W-1:0]           cap_q;
    logic [DQ_W*BURST_LEN-1:0] data_q, data_d;
    logic [3:0]                cmd_q, cmd_d;
    logic [ROW_W-1:0]          a_q, a_d;
    logic [BA_W-1:0]           ba_q, ba_d;
    logic                      ack_q, ack_d;
    logic                      vld_q, vld_d;

    // Column on the low address bits, A10 selects auto-precharge.
    function automatic logic [ROW_W-1:0] read_addr(input logic [COL_W-1:0] col);
        logic [ROW_W-1:0] a;
        a            = '0;
        a[COL_W-1:0] = col;
        a[10]        = AUTO_PRE;
        return a;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        bank_d  = bank_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req_i) begin
                    row_d   = rd_row_i;
                    col_d   = rd_col_i;
                    bank_d  = rd_bank_i;
                    ack_d   = 1'b1;
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                cnt_d   = '0;
                state_d = (TRCD == 1) ? S_READ : S_TRCD;
            end
            S_TRCD: begin
                if (cnt_q == CNT_W'(TRCD - 2)) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_CAS;
            end
            S_CAS: begin
                if (cnt_q == CNT_W'(RD_DLY - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                // cap_q holds the beat that was on dq_in one clock earlier.
                for (int k = 0; k < BURST_LEN; k++) begin
                    if (cnt_q == CNT_W'(k)) data_d[k*DQ_W +: DQ_W] = cap_q;
                end
                if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state, so each command appears
    // during the cycle its state is occupied; a/ba hold through NOPs.
    always_comb begin
        cmd_d = CMD_NOP;
        a_d   = a_q;
        ba_d  = ba_q;
        vld_d = (state_d == S_DONE);
        if (state_d == S_ACT) begin
            cmd_d = CMD_ACT;
            a_d   = row_d;
            ba_d  = bank_d;
        end else if (state_d == S_READ) begin
            cmd_d = CMD_READ;
            a_d   = read_addr(col_q);
            ba_d  = bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bank_q  <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            cmd_q   <= CMD_NOP;
            a_q     <= '0;
            ba_q    <= '0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bank_q  <= bank_d;
            cap_q   <= dq_in_i;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            ba_q    <= ba_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
        end
    end

    assign rd_bus_o   = {cmd_q, 1'b1, a_q, ba_q};
    assign rd_ack_o   = ack_q;
    assign rd_valid_o = vld_q;
    assign rd_data_o  = data_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_burst_read.sv
// Randomised scoreboard bench for sdram_burst_read across three parameter sets
// (defaults; BL=4/TRCD=3/RD_DLY=2/no auto-precharge; BL=1/TRCD=1/RD_DLY=1).
module tb_sdram_burst_read;

    localparam int NI = 3;
    localparam int P_TRCD [NI] = '{2, 3, 1};
    localparam int P_RDLY [NI] = '{3, 2, 1};
    localparam int P_BL   [NI] = '{2, 4, 1};
    localparam bit P_AP   [NI] = '{1'b1, 1'b0, 1'b1};
    localparam int K_ACK = 0, K_CMD = 1, K_DATA = 2;
    localparam logic [19:0] BUS_RST = {4'b0111, 1'b1, 13'h0, 2'h0};

    typedef struct {
        int          id;
        int          kind;
        int          cyc;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    bit          mon_en = 1'b0;
    exp_t        expq[$];
    bit          busy_map [NI][4096];

    logic        rst_s  [NI];
    logic        req_s  [NI];
    logic [12:0] row_s  [NI];
    logic [9:0]  col_s  [NI];
    logic [1:0]  ba_s   [NI];
    logic [15:0] dq_s   [NI];
    logic        ack_s  [NI];
    logic        busy_s [NI];
    logic        vld_s  [NI];
    logic [19:0] bus_s  [NI];
    logic [31:0] d0;
    logic [63:0] d1;
    logic [15:0] d2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_burst_read #(.BURST_LEN(2), .TRCD(2), .RD_DLY(3), .AUTO_PRE(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_s[0]), .rd_req_i(req_s[0]), .rd_row_i(row_s[0]),
        .rd_col_i(col_s[0]), .rd_bank_i(ba_s[0]), .rd_ack_o(ack_s[0]), .busy_o(busy_s[0]),
        .rd_bus_o(bus_s[0]), .dq_in_i(dq_s[0]), .rd_data_o(d0), .rd_valid_o(vld_s[0]));

    sdram_burst_read #(.BURST_LEN(4), .TRCD(3), .RD_DLY(2), .AUTO_PRE(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_s[1]), .rd_req_i(req_s[1]), .rd_row_i(row_s[1]),
        .rd_col_i(col_s[1]), .rd_bank_i(ba_s[1]), .rd_ack_o(ack_s[1]), .busy_o(busy_s[1]),
        .rd_bus_o(bus_s[1]), .dq_in_i(dq_s[1]), .rd_data_o(d1), .rd_valid_o(vld_s[1]));

    sdram_burst_read #(.BURST_LEN(1), .TRCD(1), .RD_DLY(1), .AUTO_PRE(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_s[2]), .rd_req_i(req_s[2]), .rd_row_i(row_s[2]),
        .rd_col_i(col_s[2]), .rd_bank_i(ba_s[2]), .rd_ack_o(ack_s[2]), .busy_o(busy_s[2]),
        .rd_bus_o(bus_s[2]), .dq_in_i(dq_s[2]), .rd_data_o(d2), .rd_valid_o(vld_s[2]));

    function automatic logic [63:0] get_data(input int id);
        case (id)
            0:       return {32'b0, d0};
            1:       return d1;
            default: return {48'b0, d2};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int kind, input int c, input logic [63:0] v);
        exp_t e;
        e.id = id; e.kind = kind; e.cyc = c; e.val = v;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s inst%0d cycle %0d: got %h, want %h", nm, id, cyc, act, expv);
        end
    endtask

    task automatic check_evt(input string nm, input int id, input int kind, input logic [63:0] act);
        int idx;
        idx = -1;
        foreach (expq[i]) begin
            if (idx < 0 && expq[i].id == id && expq[i].kind == kind) idx = i;
        end
        n_checks++;
        if (idx < 0) begin
            n_errs++;
            $display("FAIL %s inst%0d cycle %0d: got unexpected event %h, want none", nm, id, cyc, act);
        end else begin
            if (expq[idx].cyc != cyc || expq[idx].val !== act) begin
                n_errs++;
                $display("FAIL %s inst%0d: got cycle %0d value %h, want cycle %0d value %h",
                         nm, id, cyc, act, expq[idx].cyc, expq[idx].val);
            end
            expq.delete(idx);
        end
    endtask

    task automatic scramble(input int id);
        row_s[id] = 13'($urandom);
        col_s[id] = 10'($urandom);
        ba_s[id]  = 2'($urandom);
        dq_s[id]  = 16'($urandom);
    endtask

    task automatic check_reset_vals(input int id);
        chk("rst_bus", id, 64'(bus_s[id]), 64'(BUS_RST));
        chk("rst_busy", id, 64'(busy_s[id]), 64'd0);
        chk("rst_ack", id, 64'(ack_s[id]), 64'd0);
        chk("rst_valid", id, 64'(vld_s[id]), 64'd0);
        chk("rst_data", id, get_data(id), 64'd0);
    endtask

    // Transaction-level model: a burst accepted in cycle c0 yields ack and ACT at
    // c0+1, READ at c0+TRCD+1, beats from c0+TRCD+1+RD_DLY, valid at c0+len-1.
    task automatic run_inst(input int id, input int nb, input int rst_b);
        int trcd, rdly, bl, len, c0, gap, first_beat;
        logic [15:0] beats [8];
        logic [12:0] row, a;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [63:0] dexp;
        trcd = P_TRCD[id];
        rdly = P_RDLY[id];
        bl   = P_BL[id];
        len  = trcd + rdly + bl + 3;
        for (int b = 0; b < nb; b++) begin
            gap = (b < 2) ? 0 : int'($urandom_range(0, 2));
            repeat (gap) begin
                req_s[id] = 1'b0;
                scramble(id);
                step();
            end
            row  = 13'($urandom);
            col  = 10'($urandom);
            bank = 2'($urandom);
            foreach (beats[k]) beats[k] = 16'($urandom);
            if (b == 0 && id == 0) begin
                row = 13'h1ABC; col = 10'h155; bank = 2'd2;
                beats[0] = 16'hAAAA; beats[1] = 16'h5555;
            end
            if (b == 0 && id == 1) begin
                col = 10'h3FF;
                beats[0] = 16'h1111; beats[1] = 16'h2222; beats[2] = 16'h3333; beats[3] = 16'h4444;
            end
            c0 = cyc;
            first_beat = c0 + trcd + 1 + rdly;
            a = 13'(col) + (P_AP[id] ? 13'h400 : 13'h000);
            push(id, K_ACK, c0 + 1, 64'd0);
            push(id, K_CMD, c0 + 1, {44'b0, 4'b0011, 1'b1, row, bank});
            push(id, K_CMD, c0 + trcd + 1, {44'b0, 4'b0101, 1'b1, a, bank});
            if (b != rst_b) begin
                dexp = 64'd0;
                for (int k = 0; k < bl; k++) dexp |= 64'(beats[k]) << (16 * k);
                push(id, K_DATA, c0 + len - 1, dexp);
                for (int c = c0 + 1; c < c0 + len; c++) busy_map[id][c] = 1'b1;
            end else begin
                for (int c = c0 + 1; c <= c0 + 5; c++) busy_map[id][c] = 1'b1;
            end
            req_s[id] = 1'b1;
            row_s[id] = row;
            col_s[id] = col;
            ba_s[id]  = bank;
            dq_s[id]  = 16'($urandom);
            step();
            for (int t = 1; t < len; t++) begin
                if (b == rst_b && t == 5) rst_s[id] = 1'b0;
                if (b == rst_b && t == 6) begin
                    rst_s[id] = 1'b1;
                    req_s[id] = 1'b0;
                    check_reset_vals(id);
                    break;
                end
                req_s[id] = (b < 2) ? 1'b1 : 1'($urandom);
                scramble(id);
                if (cyc >= first_beat && cyc < first_beat + bl) dq_s[id] = beats[cyc - first_beat];
                step();
            end
        end
        req_s[id] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int id = 0; id < NI; id++) begin
                chk("busy", id, 64'(busy_s[id]), 64'(busy_map[id][cyc]));
                if (ack_s[id]) check_evt("ack", id, K_ACK, 64'd0);
                if (bus_s[id][19:16] != 4'b0111) check_evt("cmd", id, K_CMD, 64'(bus_s[id]));
                if (vld_s[id]) check_evt("data", id, K_DATA, get_data(id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int id = 0; id < NI; id++) begin
            rst_s[id] = 1'b0;
            req_s[id] = 1'b0;
            row_s[id] = '0;
            col_s[id] = '0;
            ba_s[id]  = '0;
            dq_s[id]  = '0;
        end
        repeat (3) step();
        for (int id = 0; id < NI; id++) rst_s[id] = 1'b1;
        for (int id = 0; id < NI; id++) check_reset_vals(id);
        mon_en = 1'b1;
        fork
            run_inst(0, 40, 4);
            run_inst(1, 40, -1);
            run_inst(2, 40, -1);
        join
        repeat (5) step();
        mon_en = 1'b0;
        n_checks++;
        if (expq.size() != 0) begin
            n_errs++;
            $display("FAIL pending: got %0d outstanding expected events, want 0", expq.size());
            foreach (expq[i])
                $display("FAIL missing inst%0d kind %0d: want cycle %0d value %h",
                         expq[i].id, expq[i].kind, expq[i].cyc, expq[i].val);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
